temporizador_multicanal: RTL and testbench



---
 rtl/temporizador_multicanal_pkg.sv | 10 +
 rtl/temporizador_multicanal_selector_canal.sv | 23 ++
 rtl/temporizador_multicanal.sv | 89 ++++++++
 tb/tb_temporizador_multicanal.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/temporizador_multicanal_pkg.sv
// temporizador_multicanal_pkg: shared state encoding, channel names and index-width helper
package temporizador_multicanal_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, FIN = 2'd2} estado_t;
    localparam int R_CH = 2;
    localparam int G_CH = 1;
    localparam int B_CH = 0;
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/temporizador_multicanal_selector_canal.sv
// selector_canal: highest set mask bit at or below start_i
module selector_canal
    import temporizador_multicanal_pkg::*;
#(
    parameter int N_CH = 3,
    parameter int IW = idx_w(N_CH)
) (
    input  logic [N_CH-1:0] mask_i,
    input  logic [IW-1:0]   start_i,
    output logic [IW-1:0]   idx_o,
    output logic            valid_o
);
    always_comb begin
        idx_o = '0;
        valid_o = 1'b0;
        for (int i = 0; i < N_CH; i++) begin
            if (mask_i[i] && i <= int'(start_i)) begin
                idx_o = IW'(i);
                valid_o = 1'b1;
            end
        end
    end
endmodule

// File: rtl/temporizador_multicanal.sv
// temporizador_multicanal: runs each eligible channel for its latched count+1 cycles,
// highest channel first, with pause, abort and busy/done status.
module temporizador_multicanal
    import temporizador_multicanal_pkg::*;
#(
    parameter int N_CH = 3,
    parameter int CNT_W = 5,
    parameter bit SKIP_ZERO = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enter,
    input  logic                  pause,
    input  logic                  abort,
    input  logic [N_CH*CNT_W-1:0] ciclos,
    output logic [N_CH-1:0]       activo,
    output logic [N_CH-1:0]       flags,
    output logic                  busy,
    output logic                  done
);
    localparam int IW = idx_w(N_CH);
    estado_t estado_q, estado_d;
    logic [IW-1:0] canal_q, canal_d, sel_idx;
    logic [CNT_W-1:0] cnt_q, cnt_d, lim;
    logic [N_CH*CNT_W-1:0] shadow_q, shadow_d;
    logic [N_CH-1:0] mask;
    logic sel_valid;
    // Start scans the live counts; hand-off scans the latched counts strictly below canal
    always_comb begin
        mask = '0;
        for (int i = 0; i < N_CH; i++) begin
            mask[i] = (estado_q == IDLE) ? (!SKIP_ZERO || |ciclos[i*CNT_W +: CNT_W])
                                         : ((!SKIP_ZERO || |shadow_q[i*CNT_W +: CNT_W]) && i < int'(canal_q));
        end
    end
    selector_canal #(.N_CH(N_CH), .IW(IW)) u_sel (
        .mask_i (mask),
        .start_i(IW'(N_CH - 1)),
        .idx_o  (sel_idx),
        .valid_o(sel_valid)
    );
    assign lim = shadow_q[int'(canal_q)*CNT_W +: CNT_W];
    always_comb begin
        estado_d = estado_q;
        canal_d = canal_q;
        cnt_d = cnt_q;
        shadow_d = shadow_q;
        activo = '0;
        flags = '0;
        busy = estado_q != IDLE;
        done = estado_q == FIN && !abort;
        if (estado_q == IDLE) begin
            if (enter) begin
                shadow_d = ciclos;
                cnt_d = '0;
                canal_d = sel_valid ? sel_idx : canal_q;
                estado_d = sel_valid ? RUN : FIN;
            end
        end else if (abort) begin
            estado_d = IDLE;
            cnt_d = '0;
        end else if (estado_q == FIN) begin
            estado_d = IDLE;
        end else if (!pause) begin
            activo[canal_q] = 1'b1;
            if (cnt_q == lim) begin
                flags[canal_q] = 1'b1;
                cnt_d = '0;
                canal_d = sel_valid ? sel_idx : canal_q;
                estado_d = sel_valid ? RUN : FIN;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            estado_q <= IDLE;
            canal_q <= '0;
            cnt_q <= '0;
            shadow_q <= '0;
        end else begin
            estado_q <= estado_d;
            canal_q <= canal_d;
            cnt_q <= cnt_d;
            shadow_q <= shadow_d;
        end
    end
endmodule

// File: tb/tb_temporizador_multicanal.sv
// tb_temporizador_multicanal: random and directed stimulus on a skipping and a non-skipping
// instance, each compared cycle by cycle against a precomputed output schedule.
module tb_temporizador_multicanal;
    import temporizador_multicanal_pkg::*;
    localparam int N = 3;
    localparam int CW = 5;
    localparam int W = N * CW;
    typedef struct packed {
        logic [N-1:0] act;
        logic [N-1:0] flg;
        logic         dn;
    } ent_t;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic enter = 1'b0;
    logic pause = 1'b0;
    logic abort = 1'b0;
    logic [W-1:0] ciclos = '0;
    logic [N-1:0] activo [2];
    logic [N-1:0] flags [2];
    logic busy [2];
    logic done [2];
    ent_t q [2][128];
    int hd [2];
    int tl [2];
    bit skip [2];
    int n_chk = 0;
    int n_err = 0;
    always #5 clk = ~clk;
    temporizador_multicanal #(.N_CH(N), .CNT_W(CW), .SKIP_ZERO(1'b1)) dut0 (
        .clk(clk), .reset(reset), .enter(enter), .pause(pause), .abort(abort), .ciclos(ciclos),
        .activo(activo[0]), .flags(flags[0]), .busy(busy[0]), .done(done[0])
    );
    temporizador_multicanal #(.N_CH(N), .CNT_W(CW), .SKIP_ZERO(1'b0)) dut1 (
        .clk(clk), .reset(reset), .enter(enter), .pause(pause), .abort(abort), .ciclos(ciclos),
        .activo(activo[1]), .flags(flags[1]), .busy(busy[1]), .done(done[1])
    );
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask
    // Whole run as a schedule: count+1 active cycles per eligible channel, then one done cycle
    task automatic build(input int k, input logic [W-1:0] c);
        int v;
        hd[k] = 0;
        tl[k] = 0;
        for (int ch = N - 1; ch >= 0; ch--) begin
            v = int'(c[ch*CW +: CW]);
            if (v != 0 || !skip[k]) begin
                for (int j = 0; j <= v; j++) begin
                    q[k][tl[k]].act = N'(1) << ch;
                    q[k][tl[k]].flg = (j == v) ? N'(1) << ch : '0;
                    q[k][tl[k]].dn = 1'b0;
                    tl[k]++;
                end
            end
        end
        q[k][tl[k]] = '{act: '0, flg: '0, dn: 1'b1};
        tl[k]++;
    endtask
    task automatic step(input logic e, input logic p, input logic a, input logic [W-1:0] c);
        @(negedge clk);
        enter = e;
        pause = p;
        abort = a;
        ciclos = c;
        #1;
        for (int k = 0; k < 2; k++) begin
            ent_t x;
            logic b;
            x = '0;
            b = hd[k] != tl[k];
            if (b && !a && !(p && !q[k][hd[k]].dn)) x = q[k][hd[k]];
            chk($sformatf("activo%0d", k), 32'(activo[k]), 32'(x.act));
            chk($sformatf("flags%0d", k), 32'(flags[k]), 32'(x.flg));
            chk($sformatf("busy%0d", k), 32'(busy[k]), 32'(b));
            chk($sformatf("done%0d", k), 32'(done[k]), 32'(x.dn));
        end
        @(posedge clk);
        for (int k = 0; k < 2; k++) begin
            if (hd[k] != tl[k]) begin
                if (a) hd[k] = tl[k];
                else if (!(p && !q[k][hd[k]].dn)) hd[k]++;
            end else if (e) begin
                build(k, c);
            end
        end
    endtask
    task automatic chk_zero(input string tag);
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("%s_activo%0d", tag, k), 32'(activo[k]), 32'd0);
            chk($sformatf("%s_flags%0d", tag, k), 32'(flags[k]), 32'd0);
            chk($sformatf("%s_busy%0d", tag, k), 32'(busy[k]), 32'd0);
            chk($sformatf("%s_done%0d", tag, k), 32'(done[k]), 32'd0);
        end
    endtask
    task automatic do_reset();
        @(negedge clk);
        enter = 1'b0;
        pause = 1'b0;
        abort = 1'b0;
        #2 reset = 1'b1;
        #1 chk_zero("async_rst");
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 2; k++) begin
            hd[k] = 0;
            tl[k] = 0;
        end
    endtask
    function automatic logic [W-1:0] rnd_c();
        logic [W-1:0] c;
        c = '0;
        for (int i = 0; i < N; i++)
            c[i*CW +: CW] = ($urandom_range(0, 3) == 0) ? CW'(0) : CW'($urandom_range(1, 7));
        return c;
    endfunction
    function automatic logic [W-1:0] pk(input int r, input int g, input int b);
        logic [W-1:0] c;
        c = '0;
        c[R_CH*CW +: CW] = CW'(r);
        c[G_CH*CW +: CW] = CW'(g);
        c[B_CH*CW +: CW] = CW'(b);
        return c;
    endfunction
    initial begin
        logic [W-1:0] rc;
        skip[0] = 1'b1;
        skip[1] = 1'b0;
        hd[0] = 0; tl[0] = 0; hd[1] = 0; tl[1] = 0;
        #2 chk_zero("reset");
        @(negedge clk);
        reset = 1'b0;
        step(1, 0, 0, pk(2, 0, 1));
        repeat (10) step(0, 0, 0, pk(2, 0, 1));
        step(1, 0, 0, pk(4, 0, 0));
        repeat (2) step(0, 0, 0, pk(4, 0, 0));
        repeat (5) step(0, 1, 0, pk(4, 0, 0));
        repeat (8) step(0, 0, 0, pk(4, 0, 0));
        step(1, 0, 0, pk(1, 2, 1));
        repeat (3) step(0, 0, 0, pk(1, 2, 1));
        step(0, 0, 1, pk(1, 2, 1));
        repeat (4) step(0, 0, 0, pk(1, 2, 1));
        step(1, 0, 0, pk(0, 0, 0));
        repeat (4) step(0, 0, 0, pk(0, 0, 0));
        step(1, 0, 0, pk(3, 1, 1));
        step(0, 0, 0, pk(3, 1, 1));
        step(1, 0, 0, pk(0, 1, 1));
        repeat (3) step(1, 0, 0, pk(0, 1, 1));
        do_reset();
        repeat (3) step(0, 0, 0, pk(0, 1, 1));
        repeat (20) step(1, 0, 0, pk(1, 0, 1));
        step(0, 0, 0, pk(1, 0, 1));
        step(1, 0, 0, pk(31, 31, 31));
        repeat (100) step(0, 0, 0, pk(31, 31, 31));
        rc = rnd_c();
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 49) == 0) rc = rnd_c();
            if ($urandom_range(0, 599) == 0) do_reset();
            step($urandom_range(0, 2) == 0, $urandom_range(0, 5) == 0, $urandom_range(0, 39) == 0, rc);
        end
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
